// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state is always present in the enum; the logic behind it only
// exists when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. The pointers are one bit wider than the address,
// so the extra MSB separates full from empty. Read data is a combinational
// view of the head entry.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance the pointers. A push into a full FIFO is dropped even when a pop
  // happens in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the pointers alone decide which entries are valid.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-buffered bytes serialized as 8N1, LSB first, with a
// per-frame latched baud divider. Defining UART_TX_PARITY_EN inserts an even
// parity bit, which makes the frame 8E1.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_en_i,
  input  logic [DIV_WIDTH-1:0]        cfg_div_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]   div_reload_q, div_reload_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   bit_done, start_frame, load;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign tx_ready_o = !fifo_full;
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  // tx_o is registered, so the line is glitch-free and falls two edges after a push.
  assign tx_o       = tx_q;

  // Next-state, bit timing and line level for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    div_reload_d = div_reload_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    tx_d         = IDLE_LEVEL;
    fifo_pop     = 1'b0;
    load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    bit_done     = (div_cnt_q == div_reload_q);
    start_frame  = cfg_en_i && !fifo_empty;

    if (state_q != IDLE) div_cnt_d = bit_done ? '0 : div_cnt_q + DIV_WIDTH'(1);

    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (start_frame) load = 1'b1;
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = IDLE_LEVEL;
        // Chain straight into the next frame so there is no idle bit between frames.
        if (bit_done) begin
          if (start_frame) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: take the head byte and freeze the divider for this frame.
    if (load) begin
      fifo_pop     = 1'b1;
      shift_d      = fifo_rdata;
      div_reload_d = cfg_div_i;
      div_cnt_d    = '0;
      bit_idx_d    = '0;
      state_d      = START;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^fifo_rdata;
`endif
    end
  end

  // Sequencer registers; reset drives the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      div_reload_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_reload_q <= div_reload_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a line-level receive monitor
// decodes tx_o and a byte scoreboard holds what was accepted.
module tb_uart_tx_serializer;

  localparam int FIFO_DEPTH = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 cfg_en_i   = 1'b0;
  logic [DIV_WIDTH-1:0] cfg_div_i  = '0;
  logic [7:0]           tx_data_i  = '0;
  logic                 tx_valid_i = 1'b0;
  logic                 tx_ready_o, tx_o, busy_o;
  logic [CW-1:0]        fifo_count_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  uart_tx_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en_i     (cfg_en_i),
    .cfg_div_i    (cfg_div_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Callers sit just after a rising edge; this returns just after the next one.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, output logic acc);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    acc        = tx_ready_o;
    @(posedge clk);
    #1;
    tx_valid_i = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic push_wait(input logic [7:0] d);
    logic acc;
    int   tries;
    tries = 0;
    do begin
      push(d, acc);
      tries++;
    end while (!acc && tries < 5000);
    if (!acc) check("push_timeout", 32'(acc), 32'd1);
  endtask

  // Wait for the first cycle of a start bit; waited = idle cycles seen before it.
  task automatic wait_start(input int limit, output int waited);
    waited = 0;
    @(negedge clk);
    while (tx_o !== 1'b0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (tx_o !== 1'b0) check("start_timeout", 32'(tx_o), 32'd0);
  endtask

  // Receive monitor: entered on the first start-bit cycle. Every bit must hold
  // for exactly div+1 cycles.
  task automatic rx_frame(input int div, output logic [7:0] data, output logic par);
    logic [FRAME_BITS-1:0] bits;
    logic                  first;
    int                    unstable;
    bits     = '0;
    first    = 1'b0;
    unstable = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) first = tx_o;
        else if (tx_o !== first) unstable++;
      end
      bits[b] = first;
    end
    data = bits[8:1];
    par  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par = bits[9];
    check("parity_even", 32'(^{data, par}), 32'd0);
`endif
    check("start_bit", 32'(bits[0]), 32'd0);
    check("stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
    check("bit_timing", 32'(unstable), 32'd0);
  endtask

  task automatic expect_frame(input int div, output logic [7:0] d, output logic p);
    logic [7:0] e;
    int         sz;
    rx_frame(div, d, p);
    sz = exp_q.size();
    if (sz == 0) check("scoreboard_underflow", 32'(sz), 32'd1);
    else begin
      e = exp_q.pop_front();
      check("rx_data", 32'(d), 32'(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, d0;
    logic       p, acc;
    int         w, nacc, n, div;

    // Reset values, checked while reset is held.
    #23;
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_ready", 32'(tx_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Single 0x55 frame, div=3: start bit two edges after the push, 40-cycle frame.
    cfg_div_i = 16'd3;
    cfg_en_i  = 1'b1;
    push(8'h55, acc);
    check("push_accept", 32'(acc), 32'd1);
    wait_start(20, w);
    check("latency", 32'(w), 32'd2);
    expect_frame(3, d, p);
    idle(2);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_tx", 32'(tx_o), 32'd1);

    // 0x41, 0x0A at 115200 baud from 50 MHz, with no gap between frames.
    cfg_div_i = 16'd433;
    push_wait(8'h41);
    push_wait(8'h0A);
    wait_start(10, w);
    expect_frame(433, d0, p);
    wait_start(10, w);
    check("b2b_gap", 32'(w), 32'd0);
    expect_frame(433, d, p);
    $display("RX string: %c", d0);
    idle(2);

    // Fill the FIFO with the transmitter disabled, then release it at div=0.
    cfg_en_i  = 1'b0;
    cfg_div_i = 16'd0;
    nacc      = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      push(8'($urandom), acc);
      nacc += int'(acc);
    end
    check("fill_accepted", 32'(nacc), 32'(FIFO_DEPTH));
    check("full_ready", 32'(tx_ready_o), 32'd0);
    check("full_count", 32'(fifo_count_o), 32'(FIFO_DEPTH));
    check("full_tx_idle", 32'(tx_o), 32'd1);
    check("full_busy", 32'(busy_o), 32'd1);
    push(8'($urandom), acc);
    check("full_reject", 32'(acc), 32'd0);
    check("full_count_hold", 32'(fifo_count_o), 32'(FIFO_DEPTH));
    cfg_en_i = 1'b1;
    @(negedge clk);
    check("ready_before_pop", 32'(tx_ready_o), 32'd0);
    @(negedge clk);
    check("ready_after_pop", 32'(tx_ready_o), 32'd1);
    check("count_after_pop", 32'(fifo_count_o), 32'(FIFO_DEPTH - 1));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      wait_start(10, w);
      check("drain_gap", 32'(w), 32'd0);
      expect_frame(0, d, p);
    end
    idle(2);

    // Divider change mid-frame applies to the next frame only.
    cfg_div_i = 16'd3;
    push_wait(8'hA5);
    push_wait(8'h3C);
    wait_start(20, w);
    fork
      expect_frame(3, d, p);
      begin
        idle(8);
        cfg_div_i = 16'd7;
      end
    join
    wait_start(10, w);
    check("div_change_gap", 32'(w), 32'd0);
    expect_frame(7, d, p);
    idle(2);

`ifdef UART_TX_PARITY_EN
    // Even parity on known bytes.
    cfg_div_i = 16'd1;
    push_wait(8'h07);
    push_wait(8'h03);
    wait_start(20, w);
    expect_frame(1, d, p);
    check("parity_07", 32'(p), 32'd1);
    wait_start(10, w);
    expect_frame(1, d, p);
    check("parity_03", 32'(p), 32'd0);
    idle(2);
`endif

    // Randomized rounds: random divider, byte count and push spacing.
    for (int r = 0; r < 3; r++) begin
      div       = int'($urandom_range(0, 4));
      n         = int'($urandom_range(1, FIFO_DEPTH));
      cfg_div_i = DIV_WIDTH'(div);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(0, 3)));
            push_wait(8'($urandom));
          end
        end
        begin
          logic [7:0] rd;
          logic       rp;
          int         rw;
          for (int i = 0; i < n; i++) begin
            wait_start(200, rw);
            expect_frame(div, rd, rp);
          end
        end
      join
      idle(2);
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during data bit 4 of a 0x00 frame, with bytes queued.
    cfg_div_i = 16'd3;
    push_wait(8'h00);
    push_wait(8'h11);
    push_wait(8'h22);
    wait_start(20, w);
    repeat (21) @(negedge clk);
    check("pre_reset_low", 32'(tx_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_o), 32'd1);
    check("async_rst_count", 32'(fifo_count_o), 32'd0);
    check("async_rst_ready", 32'(tx_ready_o), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_tx", 32'(tx_o), 32'd1);
    check("post_rst_count", 32'(fifo_count_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
